// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and widths for the write-back port arbiter
package wb_pkg;

    localparam int WB_CTRL_W = 6;
    localparam int WB_RD_W   = 5;
    localparam int WB_DATA_W = 32;

    // One buffered long-latency result; live drops when the entry must not write
    typedef struct packed {
        logic                 live;
        logic [WB_RD_W-1:0]   rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // One-hot register mask for a destination index
    function automatic logic [31:0] rd_onehot(input logic [WB_RD_W-1:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular buffer of long-latency results with WAW kill by destination
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  wb_entry_t                     i_push_entry,
    input  logic                          i_pop,
    input  logic                          i_kill_en,
    input  logic [WB_RD_W-1:0]            i_kill_rd,
    output wb_entry_t                     o_head,
    output logic [CW-1:0]                 o_count,
    output logic [DEPTH-1:0]              o_slot_live,
    output logic [DEPTH-1:0][WB_RD_W-1:0] o_slot_rd
);

    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    wb_entry_t         r_mem [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [CW-1:0]     r_count;
    wb_entry_t         w_push_entry;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    // An entry written in the same cycle as a matching kill is born dead
    always_comb begin
        w_push_entry      = i_push_entry;
        w_push_entry.live = i_push_entry.live & ~(i_kill_en && (i_push_entry.rd == i_kill_rd));
    end

    // Storage, pointers and occupancy; the push slot never equals the pop slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_vld   <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_en && (r_mem[i].rd == i_kill_rd)) r_mem[i].live <= 1'b0;
            end
            if (i_push) begin
                r_mem[r_wr] <= w_push_entry;
                r_vld[r_wr] <= 1'b1;
                r_wr        <= ptr_next(r_wr);
            end
            if (i_pop) begin
                r_vld[r_rd] <= 1'b0;
                r_rd        <= ptr_next(r_rd);
            end
            if (i_push && !i_pop)      r_count <= r_count + CW'(1);
            else if (!i_push && i_pop) r_count <= r_count - CW'(1);
        end
    end

    // Per-slot view used by the pending-register mask
    always_comb begin
        o_slot_live = '0;
        o_slot_rd   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_slot_live[i] = r_vld[i] & r_mem[i].live;
            o_slot_rd[i]   = r_mem[i].rd;
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - merges pipeline and long-latency results onto one write port (optional WB_STARVE_GUARD_EN)
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pipe_valid_i,
    input  logic                 pipe_we_i,
    input  logic [WB_RD_W-1:0]   pipe_rd_i,
    input  logic [WB_DATA_W-1:0] pipe_data_i,
    input  logic                 lu_valid_i,
    output logic                 lu_ready_o,
    input  logic [WB_RD_W-1:0]   lu_rd_i,
    input  logic [WB_DATA_W-1:0] lu_data_i,
    output logic [WB_CTRL_W-1:0] control_signal_wb,
    output logic [WB_DATA_W-1:0] data_in_wb,
    output logic [31:0]          pending_mask_o,
    output logic                 stall_o
);

    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || STARVE_LIMIT < 1) begin : g_param_check
        $error("wb_port_arbiter: DEPTH must be >= 2 and STARVE_LIMIT >= 1");
    end

    logic                          w_pipe_we;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_fifo_empty;
    wb_entry_t                     w_push_entry;
    wb_entry_t                     w_head;
    logic [CW-1:0]                 w_count;
    logic [DEPTH-1:0]              w_slot_live;
    logic [DEPTH-1:0][WB_RD_W-1:0] w_slot_rd;
    logic [31:0]                   w_mask;
    logic [WB_CTRL_W-1:0]          r_ctrl;
    logic [WB_DATA_W-1:0]          r_data;

    assign w_pipe_we    = pipe_valid_i & pipe_we_i & (pipe_rd_i != '0);
    assign w_fifo_empty = (w_count == '0);
    assign lu_ready_o   = (w_count < CW'(DEPTH));
    assign w_push       = lu_valid_i & lu_ready_o;
    assign w_pop        = ~w_pipe_we & ~w_fifo_empty;

    // Writes to x0 are accepted but can never retire
    always_comb begin
        w_push_entry      = '0;
        w_push_entry.live = (lu_rd_i != '0);
        w_push_entry.rd   = lu_rd_i;
        w_push_entry.data = lu_data_i;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_kill_en    (w_pipe_we),
        .i_kill_rd    (pipe_rd_i),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_slot_live  (w_slot_live),
        .o_slot_rd    (w_slot_rd)
    );

    // Write port: pipeline first, then FIFO head; data holds when nothing writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl <= '0;
            r_data <= '0;
        end else if (w_pipe_we) begin
            r_ctrl <= {pipe_rd_i, 1'b1};
            r_data <= pipe_data_i;
        end else if (w_pop && w_head.live) begin
            r_ctrl <= {w_head.rd, 1'b1};
            r_data <= w_head.data;
        end else begin
            r_ctrl <= '0;
        end
    end

    // Registers still owed a value by a live buffered result
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_live[i]) w_mask = w_mask | rd_onehot(w_slot_rd[i]);
        end
        w_mask[0] = 1'b0;
    end

    assign control_signal_wb = r_ctrl;
    assign data_in_wb        = r_data;
    assign pending_mask_o    = w_mask;

`ifdef WB_STARVE_GUARD_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

    logic [WW-1:0] r_wait;
    logic          r_stall;

    // Count cycles the head is blocked; pulse a single stall once the limit is seen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait  <= '0;
            r_stall <= 1'b0;
        end else begin
            if (w_fifo_empty || w_pop)   r_wait <= '0;
            else if (r_wait != WAIT_MAX) r_wait <= r_wait + WW'(1);
            r_stall <= (r_wait == WAIT_MAX) && !r_stall && !w_pop;
        end
    end

    assign stall_o = r_stall;
`else
    assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
`timescale 1ns/1ps
module tb_wb_port_arbiter;

`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pipe_valid_i = 1'b0;
    logic        pipe_we_i = 1'b0;
    logic [4:0]  pipe_rd_i = '0;
    logic [31:0] pipe_data_i = '0;
    logic        lu_valid_i = 1'b0;
    logic        lu_ready_o;
    logic [4:0]  lu_rd_i = '0;
    logic [31:0] lu_data_i = '0;
    logic [5:0]  control_signal_wb;
    logic [31:0] data_in_wb;
    logic [31:0] pending_mask_o;
    logic        stall_o;

    int n_vec = 0;
    int n_err = 0;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .pipe_valid_i      (pipe_valid_i),
        .pipe_we_i         (pipe_we_i),
        .pipe_rd_i         (pipe_rd_i),
        .pipe_data_i       (pipe_data_i),
        .lu_valid_i        (lu_valid_i),
        .lu_ready_o        (lu_ready_o),
        .lu_rd_i           (lu_rd_i),
        .lu_data_i         (lu_data_i),
        .control_signal_wb (control_signal_wb),
        .data_in_wb        (data_in_wb),
        .pending_mask_o    (pending_mask_o),
        .stall_o           (stall_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic v, input logic we, input logic [4:0] rd, input logic [31:0] d);
        pipe_valid_i = v;
        pipe_we_i    = we;
        pipe_rd_i    = rd;
        pipe_data_i  = d;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lu_valid_i = v;
        lu_rd_i    = rd;
        lu_data_i  = d;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_vec++; if (control_signal_wb !== 6'h00) begin n_err++; $display("FAIL reset_ctrl got %h want 00", control_signal_wb); end
        n_vec++; if (data_in_wb !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", data_in_wb); end
        n_vec++; if (lu_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", lu_ready_o); end
        n_vec++; if (pending_mask_o !== 32'h0) begin n_err++; $display("FAIL reset_mask got %h want 0", pending_mask_o); end
        n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall_o); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_pipe_write();
        set_pipe(1, 1, 5'd5, 32'hDEADBEEF);
        tick();
        n_vec++; if (control_signal_wb !== 6'h0B) begin n_err++; $display("FAIL pipe_ctrl got %h want 0b", control_signal_wb); end
        n_vec++; if (data_in_wb !== 32'hDEADBEEF) begin n_err++; $display("FAIL pipe_data got %h want deadbeef", data_in_wb); end
        set_pipe(0, 0, 0, 0);
        tick();
        n_vec++; if (control_signal_wb !== 6'h00) begin n_err++; $display("FAIL idle_ctrl got %h want 00", control_signal_wb); end
        n_vec++; if (data_in_wb !== 32'hDEADBEEF) begin n_err++; $display("FAIL idle_data_hold got %h want deadbeef", data_in_wb); end
    endtask

    task automatic test_lu_push();
        set_lu(1, 5'd7, 32'h1234);
        tick();
        set_lu(0, 0, 0);
        n_vec++; if (pending_mask_o !== 32'h80) begin n_err++; $display("FAIL lu_mask_set got %h want 80", pending_mask_o); end
        n_vec++; if (control_signal_wb !== 6'h00) begin n_err++; $display("FAIL lu_no_early_write got %h want 00", control_signal_wb); end
        tick();
        n_vec++; if (control_signal_wb !== 6'h0F) begin n_err++; $display("FAIL lu_ctrl got %h want 0f", control_signal_wb); end
        n_vec++; if (data_in_wb !== 32'h1234) begin n_err++; $display("FAIL lu_data got %h want 1234", data_in_wb); end
        n_vec++; if (pending_mask_o !== 32'h0) begin n_err++; $display("FAIL lu_mask_clear got %h want 0", pending_mask_o); end
    endtask

    task automatic test_backpressure();
        set_pipe(1, 1, 5'd1, 32'h100); set_lu(1, 5'd10, 32'hA0);
        tick();
        n_vec++; if (lu_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got %b want 1", lu_ready_o); end
        set_pipe(1, 1, 5'd2, 32'h200); set_lu(1, 5'd11, 32'hB0);
        tick();
        n_vec++; if (lu_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got %b want 0", lu_ready_o); end
        n_vec++; if (pending_mask_o !== 32'h0C00) begin n_err++; $display("FAIL bp_mask2 got %h want 0c00", pending_mask_o); end
        n_vec++; if (control_signal_wb !== 6'h05) begin n_err++; $display("FAIL bp_pipe2 got %h want 05", control_signal_wb); end
        set_pipe(1, 1, 5'd3, 32'h300); set_lu(1, 5'd12, 32'hC0);
        tick();
        n_vec++; if (lu_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_held got %b want 0", lu_ready_o); end
        n_vec++; if (control_signal_wb !== 6'h07 || data_in_wb !== 32'h300) begin n_err++; $display("FAIL bp_pipe3 got %h/%h want 07/300", control_signal_wb, data_in_wb); end
        n_vec++; if (pending_mask_o !== 32'h0C00) begin n_err++; $display("FAIL bp_mask_held got %h want 0c00", pending_mask_o); end
        set_pipe(0, 0, 0, 0);
        tick();
        n_vec++; if (control_signal_wb !== 6'h15 || data_in_wb !== 32'hA0) begin n_err++; $display("FAIL bp_retire_a got %h/%h want 15/a0", control_signal_wb, data_in_wb); end
        n_vec++; if (pending_mask_o !== 32'h0800 || lu_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_after_a got %h/%b want 0800/1", pending_mask_o, lu_ready_o); end
        tick();
        set_lu(0, 0, 0);
        n_vec++; if (control_signal_wb !== 6'h17 || data_in_wb !== 32'hB0) begin n_err++; $display("FAIL bp_retire_b got %h/%h want 17/b0", control_signal_wb, data_in_wb); end
        n_vec++; if (pending_mask_o !== 32'h1000) begin n_err++; $display("FAIL bp_mask_c got %h want 1000", pending_mask_o); end
        tick();
        n_vec++; if (control_signal_wb !== 6'h19 || data_in_wb !== 32'hC0) begin n_err++; $display("FAIL bp_retire_c got %h/%h want 19/c0", control_signal_wb, data_in_wb); end
        n_vec++; if (pending_mask_o !== 32'h0) begin n_err++; $display("FAIL bp_mask_empty got %h want 0", pending_mask_o); end
        tick();
        n_vec++; if (control_signal_wb !== 6'h00 || data_in_wb !== 32'hC0) begin n_err++; $display("FAIL bp_drained got %h/%h want 00/c0", control_signal_wb, data_in_wb); end
    endtask

    task automatic test_waw_kill();
        set_pipe(1, 1, 5'd9, 32'h9); set_lu(1, 5'd3, 32'h1);
        tick();
        set_lu(0, 0, 0);
        n_vec++; if (control_signal_wb !== 6'h13 || pending_mask_o !== 32'h8) begin n_err++; $display("FAIL waw_setup got %h/%h want 13/8", control_signal_wb, pending_mask_o); end
        set_pipe(1, 1, 5'd3, 32'hA);
        tick();
        n_vec++; if (control_signal_wb !== 6'h07 || data_in_wb !== 32'hA) begin n_err++; $display("FAIL waw_pipe got %h/%h want 07/a", control_signal_wb, data_in_wb); end
        n_vec++; if (pending_mask_o !== 32'h0) begin n_err++; $display("FAIL waw_mask_kill got %h want 0", pending_mask_o); end
        set_pipe(0, 0, 0, 0);
        tick();
        n_vec++; if (control_signal_wb !== 6'h00 || data_in_wb !== 32'hA) begin n_err++; $display("FAIL waw_dead_pop got %h/%h want 00/a", control_signal_wb, data_in_wb); end
        n_vec++; if (lu_ready_o !== 1'b1) begin n_err++; $display("FAIL waw_drained got %b want 1", lu_ready_o); end
        set_pipe(1, 1, 5'd4, 32'h44); set_lu(1, 5'd4, 32'h55);
        tick();
        set_pipe(0, 0, 0, 0); set_lu(0, 0, 0);
        n_vec++; if (control_signal_wb !== 6'h09 || pending_mask_o !== 32'h0) begin n_err++; $display("FAIL waw_same_cycle got %h/%h want 09/0", control_signal_wb, pending_mask_o); end
        tick();
        n_vec++; if (control_signal_wb !== 6'h00 || data_in_wb !== 32'h44) begin n_err++; $display("FAIL waw_same_pop got %h/%h want 00/44", control_signal_wb, data_in_wb); end
        set_lu(1, 5'd0, 32'h77);
        tick();
        set_lu(0, 0, 0);
        n_vec++; if (pending_mask_o !== 32'h0) begin n_err++; $display("FAIL x0_mask got %h want 0", pending_mask_o); end
        tick();
        n_vec++; if (control_signal_wb !== 6'h00 || data_in_wb !== 32'h44) begin n_err++; $display("FAIL x0_pop got %h/%h want 00/44", control_signal_wb, data_in_wb); end
    endtask

    task automatic test_starve();
        logic exp_stall;
        set_pipe(1, 1, 5'd1, 32'h0); set_lu(1, 5'd6, 32'h66);
        tick();
        set_lu(0, 0, 0);
        n_vec++; if (stall_o !== 1'b0 || pending_mask_o !== 32'h40) begin n_err++; $display("FAIL starve_start got %b/%h want 0/40", stall_o, pending_mask_o); end
        for (int c = 2; c <= 11; c++) begin
            pipe_data_i = 32'(c);
            tick();
            exp_stall = GUARD && (c == 10);
            n_vec++; if (stall_o !== exp_stall) begin n_err++; $display("FAIL starve_stall_c%0d got %b want %b", c, stall_o, exp_stall); end
        end
        set_pipe(0, 0, 0, 0);
        tick();
        n_vec++; if (control_signal_wb !== 6'h0D || data_in_wb !== 32'h66) begin n_err++; $display("FAIL starve_retire got %h/%h want 0d/66", control_signal_wb, data_in_wb); end
        n_vec++; if (stall_o !== 1'b0 || pending_mask_o !== 32'h0) begin n_err++; $display("FAIL starve_after got %b/%h want 0/0", stall_o, pending_mask_o); end
    endtask

    task automatic test_rd0_and_reset();
        set_pipe(1, 1, 5'd1, 32'h11); set_lu(1, 5'd2, 32'h22);
        tick();
        set_lu(0, 0, 0);
        n_vec++; if (control_signal_wb !== 6'h03 || pending_mask_o !== 32'h4) begin n_err++; $display("FAIL rd0_setup got %h/%h want 03/4", control_signal_wb, pending_mask_o); end
        set_pipe(1, 1, 5'd0, 32'hFF);
        tick();
        n_vec++; if (control_signal_wb !== 6'h05 || data_in_wb !== 32'h22) begin n_err++; $display("FAIL rd0_pop got %h/%h want 05/22", control_signal_wb, data_in_wb); end
        set_pipe(1, 1, 5'd1, 32'h12); set_lu(1, 5'd13, 32'hD0);
        tick();
        set_lu(1, 5'd14, 32'hE0);
        tick();
        set_lu(0, 0, 0); set_pipe(0, 0, 0, 0);
        n_vec++; if (pending_mask_o !== 32'h6000 || lu_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_pre got %h/%b want 6000/0", pending_mask_o, lu_ready_o); end
        reset = 1'b0;
        #1;
        n_vec++; if (control_signal_wb !== 6'h00 || data_in_wb !== 32'h0) begin n_err++; $display("FAIL rst_async_out got %h/%h want 00/0", control_signal_wb, data_in_wb); end
        n_vec++; if (pending_mask_o !== 32'h0 || lu_ready_o !== 1'b1 || stall_o !== 1'b0) begin n_err++; $display("FAIL rst_async_state got %h/%b/%b want 0/1/0", pending_mask_o, lu_ready_o, stall_o); end
        tick();
        reset = 1'b1;
        tick();
        n_vec++; if (control_signal_wb !== 6'h00 || pending_mask_o !== 32'h0 || lu_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_empty got %h/%h/%b want 00/0/1", control_signal_wb, pending_mask_o, lu_ready_o); end
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_lu_push();
        test_backpressure();
        test_waw_kill();
        test_starve();
        test_rd0_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Merges in-order pipeline results and out-of-order long-latency results (divider, uncached loads) onto the single register-file write port that the decode stage consumes as `control_signal_wb`/`data_in_wb`. It sits at the end of the MEM/WB boundary, buffers long-latency results in a small FIFO, and keeps them ordered against newer pipeline writes. It exports a pending-register mask for the hazard unit and a stall request that prevents starvation.

## Interface
- `DEPTH`, 2: long-latency FIFO entries (≥2).
- `STARVE_LIMIT`, 8: cycles a FIFO head may wait before a stall is requested.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `pipe_valid_i`  in  1  pipeline result present this cycle.
- `pipe_we_i`  in  1  pipeline result writes a register.
- `pipe_rd_i`  in  5  pipeline destination.
- `pipe_data_i`  in  32  pipeline result.
- `lu_valid_i`  in  1  long-latency result offered.
- `lu_ready_o`  out  1  FIFO accepts; transfer when valid&ready.
- `lu_rd_i`  in  5  long-latency destination.
- `lu_data_i`  in  32  long-latency result.
- `control_signal_wb`  out  6  {rd[4:0], we}; registered.
- `data_in_wb`  out  32  write data; registered.
- `pending_mask_o`  out  32  bit r set while a live FIFO entry targets xr.
- `stall_o`  out  1  upstream must present `pipe_valid_i`=0 next cycle (see Configuration).

## Operation
- Effective pipe write: `pipe_we_eff = pipe_valid_i & pipe_we_i & (pipe_rd_i != 0)`.
- Per-cycle selection, in priority order:
  1. `pipe_we_eff` → register {pipe_rd, 1}, pipe_data.
  2. FIFO non-empty → pop head. Live head → {head.rd, 1}, head.data. Killed head → {0, 0}, data held.
  3. Otherwise → {0, 0}, `data_in_wb` holds.
- Push: `lu_valid_i & lu_ready_o`. `lu_ready_o = (count < DEPTH)`, derived from state only. No same-cycle pass-through when full. There is no bypass: every long-latency result goes through the FIFO.
- Push and pop in the same cycle are legal. Count is unchanged.
- Results with `lu_rd_i == 0` are pushed but marked killed.
- WAW kill: when `pipe_we_eff`, every FIFO entry whose rd equals `pipe_rd_i` is marked killed. This includes the entry pushed in that same cycle. A killed entry never writes.
- `pending_mask_o`: OR of one-hot(rd) over live entries. Combinational from registered state. Bit 0 is always 0.
- Starvation counter `wait_cnt`:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on pop or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- Reset mid-operation discards all FIFO contents, including live entries. Upstream reissues.

## Timing
- Pipe result → write port: 1 cycle (registered).
- Long-latency handshake → earliest write: 2 cycles (push, then pop on an idle pipe slot).
- `pending_mask_o` reflects a push from the cycle after the push edge. It clears in the cycle the entry is popped (registered).
- `stall_o` is registered. It is high for exactly one cycle, on the cycle after `wait_cnt` reaches `STARVE_LIMIT`. The counter clears when the forced pop occurs.
- Reset values:
  - `control_signal_wb` = 0, `data_in_wb` = 0.
  - `lu_ready_o` = 1, `pending_mask_o` = 0, `stall_o` = 0.
  - FIFO empty, `wait_cnt` = 0.

## Configuration
- `WB_STARVE_GUARD_EN`:
  - Defined: the starvation counter and `stall_o` are implemented as above.
  - Undefined: the counter is removed and `stall_o` is tied to 0. The FIFO drains only in naturally idle pipe slots, and a long pipe write burst can hold `lu_ready_o` low indefinitely.

## Structure
- Package `wb_pkg`:
  - `wb_entry_t` {live, rd[4:0], data[31:0]}.
  - `WB_CTRL_W` = 6.
  - `WB_RD_W` = 5.
- Sub-module `wb_fifo`:
  - Parameterised circular buffer of `wb_entry_t`, depth `DEPTH`.
  - Ports: push, pop, head, count.
  - Kill port `kill_rd`/`kill_en`, which clears `live` on matching entries.
- The top level holds selection, output registers, mask OR, and the starvation counter.

## Test plan
- Pipe write rd=5, data 0xDEADBEEF, FIFO empty → next cycle `control_signal_wb`=0x0B, `data_in_wb`=0xDEADBEEF.
- Pipe idle, lu push rd=7 data 0x1234 → next cycle `pending_mask_o`=0x80. Cycle after that: `control_signal_wb`=0x0F, `data_in_wb`=0x1234, then mask returns to 0.
- DEPTH=2, pipe writes every cycle, three lu offers → `lu_ready_o` drops after two pushes and the third is held. When the pipe goes idle, entries retire in order.
- FIFO holds rd=3 data 0x1, then pipe writes rd=3 data 0xA → x3 written with 0xA. Head later pops with we=0, and `pending_mask_o` bit 3 clears at the kill.
- With `WB_STARVE_GUARD_EN`, continuous pipe writes plus one FIFO entry → `stall_o` high for exactly one cycle after 8 waiting cycles. The head writes on the stalled slot. Without the macro, `stall_o` stays 0.
- Pipe rd=0 with FIFO non-empty → head pops that cycle. Then assert reset with 2 live entries → all outputs return to reset values and the FIFO is empty.
